// File: rtl/tron_game_ctrl.sv
// Game sequencer for the Tron snake: start delay, frame-paced stepping, direction filter, speed-up, score.
// Optional build macro TRON_PAUSE_EN adds the pause_req input and a PAUSED state.
module tron_game_ctrl #(
    parameter int INIT_PERIOD   = 6,
    parameter int MIN_PERIOD    = 2,
    parameter int SPEEDUP_STEPS = 16,
    parameter int START_DELAY   = 60,
    parameter int SCORE_W       = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic [4:0]         dir_in,
    input  logic               start_req,
`ifdef TRON_PAUSE_EN
    input  logic               pause_req,
`endif
    input  logic               collision,
    output logic               init_snake,
    output logic               step,
    output logic [4:0]         dir_out,
    output logic               playing,
    output logic               game_over,
    output logic [SCORE_W-1:0] score,
    output logic [3:0]         period,
    output logic [2:0]         state_dbg
);

    localparam int CNT_W = $clog2(START_DELAY + 16);
    localparam int STC_W = $clog2(SPEEDUP_STEPS + 1);

    localparam logic [4:0] DIR_UP    = 5'b00010;
    localparam logic [4:0] DIR_LEFT  = 5'b00100;
    localparam logic [4:0] DIR_DOWN  = 5'b01000;
    localparam logic [4:0] DIR_RIGHT = 5'b10000;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INIT   = 3'd1,
        S_WAIT   = 3'd2,
        S_RUN    = 3'd3,
        S_OVER   = 3'd4,
        S_PAUSED = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STC_W-1:0]   stcnt_q, stcnt_d;
    logic [3:0]         period_q, period_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [4:0]         dir_q, dir_d;
    logic [4:0]         pend_q, pend_d;
    logic               step_q, step_d;

    logic [4:0] rev_dir;
    logic       dir_legal;
    logic [4:0] pend_next;
    logic       pause_evt;

    // Opposite of the committed heading: up<->down, left<->right.
    assign rev_dir   = {dir_q[2], dir_q[1], dir_q[4], dir_q[3], 1'b0};
    assign dir_legal = ((dir_in == DIR_UP) || (dir_in == DIR_LEFT) ||
                        (dir_in == DIR_DOWN) || (dir_in == DIR_RIGHT)) &&
                       (dir_in != rev_dir);
    assign pend_next = dir_legal ? dir_in : pend_q;

`ifdef TRON_PAUSE_EN
    assign pause_evt = pause_req;
`else
    assign pause_evt = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stcnt_d  = stcnt_q;
        period_d = period_q;
        score_d  = score_q;
        dir_d    = dir_q;
        pend_d   = pend_next;
        step_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_req) state_d = S_INIT;
            end
            S_INIT: begin
                state_d  = S_WAIT;
                dir_d    = DIR_RIGHT;
                pend_d   = DIR_RIGHT;
                score_d  = '0;
                period_d = 4'(INIT_PERIOD);
                cnt_d    = '0;
                stcnt_d  = '0;
            end
            S_WAIT: begin
                if (frame_tick) begin
                    if (cnt_q == CNT_W'(START_DELAY - 1)) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (pause_evt) begin
                    state_d = S_PAUSED;
                end else if (frame_tick) begin
                    if (collision) begin
                        state_d = S_OVER;
                    end else if (cnt_q == CNT_W'(period_q) - CNT_W'(1)) begin
                        // The step strobe, heading, score and speed all update on the same edge.
                        cnt_d  = '0;
                        step_d = 1'b1;
                        dir_d  = pend_next;
                        if (score_q != '1) score_d = score_q + 1'b1;
                        if (stcnt_q == STC_W'(SPEEDUP_STEPS - 1)) begin
                            stcnt_d = '0;
                            if (period_q > 4'(MIN_PERIOD)) period_d = period_q - 1'b1;
                        end else begin
                            stcnt_d = stcnt_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_PAUSED: begin
                if (start_req)      state_d = S_INIT;
                else if (pause_evt) state_d = S_RUN;
            end
            S_OVER: begin
                if (start_req) state_d = S_INIT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            stcnt_q  <= '0;
            period_q <= 4'(INIT_PERIOD);
            score_q  <= '0;
            dir_q    <= DIR_RIGHT;
            pend_q   <= DIR_RIGHT;
            step_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            stcnt_q  <= stcnt_d;
            period_q <= period_d;
            score_q  <= score_d;
            dir_q    <= dir_d;
            pend_q   <= pend_d;
            step_q   <= step_d;
        end
    end

    assign init_snake = (state_q == S_INIT);
    assign step       = step_q;
    assign dir_out    = dir_q;
    assign playing    = (state_q == S_WAIT) || (state_q == S_RUN) || (state_q == S_PAUSED);
    assign game_over  = (state_q == S_OVER);
    assign score      = score_q;
    assign period     = period_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_tron_game_ctrl.sv
// Directed bench for tron_game_ctrl: start delay, stepping, direction filter, speed-up, collision, reset.
// Define TRON_PAUSE_EN for both bench and design to exercise the pause feature.
module tb_tron_game_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic [4:0] dir_in;
    logic       start_req;
    logic       collision;
`ifdef TRON_PAUSE_EN
    logic       pause_req;
`endif
    logic       init_snake;
    logic       step;
    logic [4:0] dir_out;
    logic       playing;
    logic       game_over;
    logic [9:0] score;
    logic [3:0] period;
    logic [2:0] state_dbg;

    int n_checks = 0;
    int n_fail   = 0;
    int inits_seen = 0;
    int steps_seen = 0;
    logic [9:0] exp_score;

    tron_game_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .dir_in     (dir_in),
        .start_req  (start_req),
`ifdef TRON_PAUSE_EN
        .pause_req  (pause_req),
`endif
        .collision  (collision),
        .init_snake (init_snake),
        .step       (step),
        .dir_out    (dir_out),
        .playing    (playing),
        .game_over  (game_over),
        .score      (score),
        .period     (period),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    // Pulse monitor: counts strobes and checks they never overlap.
    always @(negedge clk) begin
        if (!reset && (init_snake || step)) begin
            n_checks++;
            if (init_snake && step) begin
                n_fail++;
                $display("FAIL strobe_overlap: init_snake=%0b step=%0b required not both 1", init_snake, step);
            end
            if (init_snake) inits_seen++;
            if (step) steps_seen++;
        end
    end

    task automatic pulse_start();
        @(negedge clk); start_req = 1'b1;
        @(negedge clk); start_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic drive_dir(input logic [4:0] d);
        @(negedge clk); dir_in = d;
        @(negedge clk); dir_in = 5'b0;
    endtask

    task automatic tick(input logic coll, output logic stepped);
        @(negedge clk); frame_tick = 1'b1; collision = coll;
        @(negedge clk); frame_tick = 1'b0; collision = 1'b0;
        stepped = step;
    endtask

    task automatic tick_n(input int n, input logic coll, output int nsteps, output logic last);
        logic s;
        nsteps = 0;
        last   = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick(coll, s);
            if (s) nsteps++;
            last = s;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; frame_tick = 1'b0; dir_in = 5'b0; start_req = 1'b0; collision = 1'b0;
`ifdef TRON_PAUSE_EN
        pause_req = 1'b0;
`endif
        repeat (3) @(negedge clk);
        n_checks++;
        if ({init_snake, step, dir_out, playing, game_over, score, period, state_dbg} !==
            {1'b0, 1'b0, 5'b10000, 1'b0, 1'b0, 10'd0, 4'd6, 3'd0}) begin
            n_fail++;
            $display("FAIL reset_values: init=%0b step=%0b dir=%b play=%0b over=%0b score=%0d period=%0d state=%0d required 0 0 10000 0 0 0 6 0",
                     init_snake, step, dir_out, playing, game_over, score, period, state_dbg);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_start();
        int i0, n;
        logic s, last;
        i0 = inits_seen;
        pulse_start();
        n_checks++;
        if (inits_seen !== i0 + 1 || playing !== 1'b1) begin
            n_fail++;
            $display("FAIL start_init: init pulses=%0d playing=%0b required %0d 1", inits_seen - i0, playing, 1);
        end
        tick_n(60, 1'b0, n, last);
        n_checks++;
        if (n !== 0 || playing !== 1'b1 || game_over !== 1'b0) begin
            n_fail++;
            $display("FAIL start_wait: steps=%0d playing=%0b over=%0b required 0 1 0", n, playing, game_over);
        end
        tick_n(5, 1'b0, n, last);
        n_checks++;
        if (n !== 0) begin
            n_fail++;
            $display("FAIL first_step_early: steps=%0d required 0", n);
        end
        tick(1'b0, s);
        n_checks++;
        if (s !== 1'b1 || score !== 10'd1 || dir_out !== 5'b10000) begin
            n_fail++;
            $display("FAIL first_step: step=%0b score=%0d dir=%b required 1 1 10000", s, score, dir_out);
        end
        i0 = inits_seen;
        pulse_start();
        n_checks++;
        if (inits_seen !== i0 || score !== 10'd1 || state_dbg !== 3'd3) begin
            n_fail++;
            $display("FAIL start_ignored_run: inits=%0d score=%0d state=%0d required 0 1 3", inits_seen - i0, score, state_dbg);
        end
        exp_score = 10'd1;
    endtask

    task automatic test_direction();
        int n;
        logic last;
        drive_dir(5'b00100);
        tick_n(6, 1'b0, n, last);
        exp_score++;
        n_checks++;
        if (n !== 1 || !last || dir_out !== 5'b10000 || score !== exp_score) begin
            n_fail++;
            $display("FAIL dir_reverse_left: steps=%0d dir=%b score=%0d required 1 10000 %0d", n, dir_out, score, exp_score);
        end
        drive_dir(5'b00010);
        n_checks++;
        if (dir_out !== 5'b10000) begin
            n_fail++;
            $display("FAIL dir_held_until_step: dir=%b required 10000", dir_out);
        end
        tick_n(6, 1'b0, n, last);
        exp_score++;
        n_checks++;
        if (n !== 1 || dir_out !== 5'b00010 || score !== exp_score) begin
            n_fail++;
            $display("FAIL dir_up: steps=%0d dir=%b score=%0d required 1 00010 %0d", n, dir_out, score, exp_score);
        end
        drive_dir(5'b01000);
        drive_dir(5'b11000);
        drive_dir(5'b00011);
        tick_n(6, 1'b0, n, last);
        exp_score++;
        n_checks++;
        if (n !== 1 || dir_out !== 5'b00010) begin
            n_fail++;
            $display("FAIL dir_illegal_ignored: steps=%0d dir=%b required 1 00010", n, dir_out);
        end
        drive_dir(5'b00100);
        drive_dir(5'b10000);
        tick_n(6, 1'b0, n, last);
        exp_score++;
        n_checks++;
        if (n !== 1 || dir_out !== 5'b10000 || score !== exp_score) begin
            n_fail++;
            $display("FAIL dir_last_wins: steps=%0d dir=%b score=%0d required 1 10000 %0d", n, dir_out, score, exp_score);
        end
    endtask

    task automatic test_speedup();
        int n, bad;
        logic last;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick_n(6, 1'b0, n, last);
            if (n != 1 || !last) bad++;
            exp_score++;
        end
        n_checks++;
        if (bad !== 0 || period !== 4'd6) begin
            n_fail++;
            $display("FAIL speed_before_16: bad_steps=%0d period=%0d required 0 6", bad, period);
        end
        tick_n(6, 1'b0, n, last);
        exp_score++;
        n_checks++;
        if (n !== 1 || period !== 4'd5) begin
            n_fail++;
            $display("FAIL speed_first_dec: steps=%0d period=%0d required 1 5", n, period);
        end
        for (int p = 5; p >= 2; p--) begin
            bad = 0;
            for (int i = 0; i < 16; i++) begin
                tick_n(p, 1'b0, n, last);
                if (n != 1 || !last) bad++;
                exp_score++;
            end
            n_checks++;
            if (bad !== 0 || period !== 4'((p > 2) ? p - 1 : 2)) begin
                n_fail++;
                $display("FAIL speed_period_%0d: bad_steps=%0d period=%0d required 0 %0d", p, bad, period, (p > 2) ? p - 1 : 2);
            end
        end
        n_checks++;
        if (score !== 10'd80 || exp_score !== 10'd80) begin
            n_fail++;
            $display("FAIL speed_score: score=%0d required 80", score);
        end
    endtask

    task automatic test_collision();
        int n, i0;
        logic s, last;
        tick(1'b0, s);
        tick(1'b1, s);
        n_checks++;
        if (s !== 1'b0 || game_over !== 1'b1 || playing !== 1'b0 || score !== exp_score) begin
            n_fail++;
            $display("FAIL collision_wins: step=%0b over=%0b playing=%0b score=%0d required 0 1 0 %0d", s, game_over, playing, score, exp_score);
        end
        drive_dir(5'b00010);
        tick_n(3, 1'b0, n, last);
        n_checks++;
        if (n !== 0 || score !== exp_score || dir_out !== 5'b10000 || game_over !== 1'b1) begin
            n_fail++;
            $display("FAIL over_frozen: steps=%0d score=%0d dir=%b over=%0b required 0 %0d 10000 1", n, score, dir_out, game_over, exp_score);
        end
        i0 = inits_seen;
        @(negedge clk); start_req = 1'b1; frame_tick = 1'b1;
        @(negedge clk); start_req = 1'b0; frame_tick = 1'b0;
        @(negedge clk);
        n_checks++;
        if (inits_seen !== i0 + 1 || score !== 10'd0 || dir_out !== 5'b10000 || period !== 4'd6 ||
            game_over !== 1'b0 || playing !== 1'b1) begin
            n_fail++;
            $display("FAIL restart: inits=%0d score=%0d dir=%b period=%0d over=%0b playing=%0b required 1 0 10000 6 0 1",
                     inits_seen - i0, score, dir_out, period, game_over, playing);
        end
        tick_n(60, 1'b1, n, last);
        n_checks++;
        if (n !== 0 || game_over !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_ignores_collision: steps=%0d over=%0b required 0 0", n, game_over);
        end
        tick_n(5, 1'b0, n, last);
        tick(1'b0, s);
        n_checks++;
        if (n !== 0 || s !== 1'b1 || score !== 10'd1 || dir_out !== 5'b10000) begin
            n_fail++;
            $display("FAIL restart_first_step: early=%0d step=%0b score=%0d dir=%b required 0 1 1 10000", n, s, score, dir_out);
        end
    endtask

`ifdef TRON_PAUSE_EN
    task automatic test_pause();
        int n;
        logic s, last;
        tick_n(2, 1'b0, n, last);
        @(negedge clk); pause_req = 1'b1;
        @(negedge clk); pause_req = 1'b0;
        tick_n(20, 1'b1, n, last);
        n_checks++;
        if (n !== 0 || game_over !== 1'b0 || playing !== 1'b1) begin
            n_fail++;
            $display("FAIL pause_hold: steps=%0d over=%0b playing=%0b required 0 0 1", n, game_over, playing);
        end
        @(negedge clk); pause_req = 1'b1;
        @(negedge clk); pause_req = 1'b0;
        tick_n(3, 1'b0, n, last);
        tick(1'b0, s);
        n_checks++;
        if (n !== 0 || s !== 1'b1 || score !== 10'd2) begin
            n_fail++;
            $display("FAIL pause_resume: early=%0d step=%0b score=%0d required 0 1 2", n, s, score);
        end
    endtask
`endif

    task automatic test_reset_midrun();
        int budget, i0, s0, n;
        logic s, last;
        budget = 2000;
        while (score != 10'd37 && budget > 0) begin
            tick(1'b0, s);
            budget--;
        end
        n_checks++;
        if (score !== 10'd37) begin
            n_fail++;
            $display("FAIL reach_score_37: score=%0d required 37", score);
        end
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (state_dbg !== 3'd0 || score !== 10'd0 || playing !== 1'b0 || period !== 4'd6 ||
            dir_out !== 5'b10000 || step !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: state=%0d score=%0d playing=%0b period=%0d dir=%b step=%0b required 0 0 0 6 10000 0",
                     state_dbg, score, playing, period, dir_out, step);
        end
        @(negedge clk); reset = 1'b0;
        i0 = inits_seen;
        s0 = steps_seen;
        tick_n(8, 1'b0, n, last);
        n_checks++;
        if (steps_seen !== s0 || inits_seen !== i0 || playing !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: steps=%0d inits=%0d playing=%0b required 0 0 0", steps_seen - s0, inits_seen - i0, playing);
        end
        pulse_start();
        n_checks++;
        if (inits_seen !== i0 + 1 || playing !== 1'b1) begin
            n_fail++;
            $display("FAIL resume_after_reset: inits=%0d playing=%0b required 1 1", inits_seen - i0, playing);
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_direction();
        test_speedup();
        test_collision();
`ifdef TRON_PAUSE_EN
        test_pause();
`endif
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
